harmonic_phase_bank: RTL and testbench

- Parametrised successor to the single-bank harmonic sample-position block.
- Owns the phase accumulators for NUM_HARMONICS harmonics and sequences them itself once per output-sample frame.
- For each harmonic, computes the detuned step frequency, advances the stored phase, drives an external sine LUT, and hands the sample to the top-level mixer over a ready/next handshake.
- Adds over the previous generation: internal harmonic sequencing, selectable detune mode, zero-clamped detune, a frame-done strobe, and a phase-sync (hard sync) clear.

---
 rtl/harmonic_phase_bank.sv | 213 +++++++++++++++++++++
 tb/tb_harmonic_phase_bank.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harmonic_phase_bank.sv
// harmonic_phase_bank: per-harmonic phase accumulators sequenced once per frame,
// with detuned step generation, sine LUT addressing and a ready/next sample handshake.
module harmonic_phase_bank #(
  parameter int unsigned NUM_HARMONICS = 64,
  parameter int unsigned PHASE_W       = 16,
  parameter int unsigned LUT_ADDR_W    = 11,
  parameter int unsigned SAMPLE_W      = 16,
  parameter int unsigned FREQ_LIMIT    = 20000,
  parameter int unsigned DETUNE_MODE   = 0,
  localparam int unsigned HARM_W       = $clog2(NUM_HARMONICS)
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_Frame_Start,
  input  logic [PHASE_W-1:0]    i_Frequency,
  input  logic [PHASE_W-1:0]    i_Freq_Offset,
  input  logic                  i_Phase_Sync,
  output logic [LUT_ADDR_W-1:0] o_LUT_Addr,
  input  logic [SAMPLE_W-1:0]   i_LUT_Data,
  output logic [SAMPLE_W-1:0]   o_Sample_Value,
  output logic [HARM_W-1:0]     o_Harmonic,
  output logic                  o_Sample_Ready,
  input  logic                  i_Next_Sample,
  output logic                  o_Frame_Done,
  output logic                  o_Freq_Too_High
);

  localparam int unsigned ACC_W  = PHASE_W + HARM_W;
  localparam int unsigned FULL_W = ACC_W + 1;
  localparam logic [HARM_W-1:0]        LAST_H = HARM_W'(NUM_HARMONICS - 1);
  localparam logic signed [FULL_W-1:0] LIMIT  = FULL_W'(FREQ_LIMIT);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_FREQ, S_PHASE, S_LUTWAIT, S_READY
  } state_t;

  state_t                  state_q, state_d;
  logic [HARM_W-1:0]       h_q, h_d;
  logic [PHASE_W-1:0]      f_q, f_d;
  logic [PHASE_W-1:0]      off_q, off_d;
  logic [ACC_W-1:0]        harm_acc_q, harm_acc_d;   // (h+1)*f
  logic [ACC_W-1:0]        off_acc_q, off_acc_d;     // h*offset
  logic [PHASE_W-1:0]      step_q, step_d;
  logic [PHASE_W-1:0]      phase_rd_q, phase_rd_d;
  logic                    sync_pend_q, sync_pend_d;
  logic [LUT_ADDR_W-1:0]   lut_addr_q, lut_addr_d;
  logic [SAMPLE_W-1:0]     sample_q, sample_d;
  logic [HARM_W-1:0]       harm_q, harm_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    too_high_q, too_high_d;

  logic [PHASE_W-1:0]      phase_mem [NUM_HARMONICS];
  logic                    mem_we_c;
  logic [PHASE_W-1:0]      mem_wdata_c;

  logic signed [FULL_W-1:0] harm_ext_c, off_ext_c, f_raw_c, f_clamp_c;
  logic                     too_high_c;
  logic [PHASE_W-1:0]       phase_sum_c;

  // Detuned step for the current harmonic, clamped at zero and checked against the limit
  always_comb begin
    harm_ext_c = $signed({1'b0, harm_acc_q});
    off_ext_c  = $signed({1'b0, off_acc_q});
    if ((DETUNE_MODE == 1) || h_q[0]) begin
      f_raw_c = harm_ext_c + off_ext_c;
    end else begin
      f_raw_c = harm_ext_c - off_ext_c;
    end
    f_clamp_c   = f_raw_c[FULL_W-1] ? '0 : f_raw_c;
    too_high_c  = (f_clamp_c > LIMIT);
    phase_sum_c = phase_rd_q + step_q;
  end

  // Phase storage: single write port, not reset (cleared by S_CLEAR instead)
  always_ff @(posedge i_Clock) begin
    if (mem_we_c) begin
      phase_mem[h_q] <= mem_wdata_c;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    f_d         = f_q;
    off_d       = off_q;
    harm_acc_d  = harm_acc_q;
    off_acc_d   = off_acc_q;
    step_d      = step_q;
    phase_rd_d  = phase_rd_q;
    sync_pend_d = sync_pend_q | i_Phase_Sync;
    lut_addr_d  = lut_addr_q;
    sample_d    = sample_q;
    harm_d      = harm_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    too_high_d  = too_high_q;
    mem_we_c    = 1'b0;
    mem_wdata_c = '0;

    case (state_q)
      S_CLEAR: begin
        mem_we_c = 1'b1;
        if (h_q == LAST_H) begin
          h_d     = '0;
          state_d = S_IDLE;
        end else begin
          h_d = h_q + HARM_W'(1);
        end
      end
      S_IDLE: begin
        // A sync request beats a coincident frame start
        if (sync_pend_d) begin
          sync_pend_d = 1'b0;
          h_d         = '0;
          state_d     = S_CLEAR;
        end else if (i_Frame_Start) begin
          f_d        = i_Frequency;
          off_d      = i_Freq_Offset;
          h_d        = '0;
          harm_acc_d = ACC_W'(i_Frequency);
          off_acc_d  = '0;
          too_high_d = 1'b0;
          state_d    = S_FREQ;
        end
      end
      S_FREQ: begin
        step_d     = f_clamp_c[PHASE_W-1:0];
        phase_rd_d = phase_mem[h_q];
        if (too_high_c) begin
          too_high_d = 1'b1;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_PHASE;
        end
      end
      S_PHASE: begin
        mem_we_c    = 1'b1;
        mem_wdata_c = phase_sum_c;
        lut_addr_d  = phase_sum_c[PHASE_W-1 -: LUT_ADDR_W];
        state_d     = S_LUTWAIT;
      end
      S_LUTWAIT: begin
        sample_d = i_LUT_Data;
        harm_d   = h_q;
        ready_d  = 1'b1;
        state_d  = S_READY;
      end
      S_READY: begin
        if (i_Next_Sample) begin
          ready_d = 1'b0;
          if (h_q == LAST_H) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            h_d        = h_q + HARM_W'(1);
            harm_acc_d = harm_acc_q + ACC_W'(f_q);
            off_acc_d  = off_acc_q + ACC_W'(off_q);
            state_d    = S_FREQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= S_CLEAR;
      h_q         <= '0;
      f_q         <= '0;
      off_q       <= '0;
      harm_acc_q  <= '0;
      off_acc_q   <= '0;
      step_q      <= '0;
      phase_rd_q  <= '0;
      sync_pend_q <= 1'b0;
      lut_addr_q  <= '0;
      sample_q    <= '0;
      harm_q      <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      too_high_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      f_q         <= f_d;
      off_q       <= off_d;
      harm_acc_q  <= harm_acc_d;
      off_acc_q   <= off_acc_d;
      step_q      <= step_d;
      phase_rd_q  <= phase_rd_d;
      sync_pend_q <= sync_pend_d;
      lut_addr_q  <= lut_addr_d;
      sample_q    <= sample_d;
      harm_q      <= harm_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      too_high_q  <= too_high_d;
    end
  end

  assign o_LUT_Addr      = lut_addr_q;
  assign o_Sample_Value  = sample_q;
  assign o_Harmonic      = harm_q;
  assign o_Sample_Ready  = ready_q;
  assign o_Frame_Done    = done_q;
  assign o_Freq_Too_High = too_high_q;

endmodule

// File: tb/tb_harmonic_phase_bank.sv
// Testbench for harmonic_phase_bank: two instances (detune modes 0 and 1) driven in
// lockstep and checked against an arithmetic per-harmonic phase model.
module tb_harmonic_phase_bank;

  localparam int unsigned N     = 4;
  localparam int unsigned PW    = 16;
  localparam int unsigned LAW   = 11;
  localparam int unsigned SW    = 16;
  localparam int unsigned HW    = 2;
  localparam int          LIMIT = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          frame_start = 1'b0;
  logic [PW-1:0] freq = '0;
  logic [PW-1:0] offs = '0;
  logic          phase_sync = 1'b0;
  logic          next_sample = 1'b0;

  logic [LAW-1:0] addr0, addr1;
  logic [SW-1:0]  lut0, lut1, sample0, sample1;
  logic [HW-1:0]  harm0, harm1;
  logic           rdy0, rdy1, done0, done1, too0, too1;

  int checks = 0;
  int errors = 0;
  int ph0[N];
  int ph1[N];

  // Arbitrary but distinct sine-table stand-in
  function automatic logic [SW-1:0] lut_fn(input logic [LAW-1:0] a);
    return {a[4:0], a} ^ 16'hA5C3;
  endfunction

  assign lut0 = lut_fn(addr0);
  assign lut1 = lut_fn(addr1);

  always #5 clk = ~clk;

  harmonic_phase_bank #(.NUM_HARMONICS(N), .PHASE_W(PW), .LUT_ADDR_W(LAW), .SAMPLE_W(SW),
                        .FREQ_LIMIT(LIMIT), .DETUNE_MODE(0)) u_dut0 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Frame_Start(frame_start), .i_Frequency(freq),
    .i_Freq_Offset(offs), .i_Phase_Sync(phase_sync), .o_LUT_Addr(addr0), .i_LUT_Data(lut0),
    .o_Sample_Value(sample0), .o_Harmonic(harm0), .o_Sample_Ready(rdy0),
    .i_Next_Sample(next_sample), .o_Frame_Done(done0), .o_Freq_Too_High(too0));

  harmonic_phase_bank #(.NUM_HARMONICS(N), .PHASE_W(PW), .LUT_ADDR_W(LAW), .SAMPLE_W(SW),
                        .FREQ_LIMIT(LIMIT), .DETUNE_MODE(1)) u_dut1 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Frame_Start(frame_start), .i_Frequency(freq),
    .i_Freq_Offset(offs), .i_Phase_Sync(phase_sync), .o_LUT_Addr(addr1), .i_LUT_Data(lut1),
    .o_Sample_Value(sample1), .o_Harmonic(harm1), .o_Sample_Ready(rdy1),
    .i_Next_Sample(next_sample), .o_Frame_Done(done1), .o_Freq_Too_High(too1));

  // Step frequency of harmonic h from the detune rule, clamped at zero
  function automatic int model_f(input int h, input int f, input int off, input int mode);
    int v;
    v = (h + 1) * f + (((mode == 1) || (h % 2 == 1)) ? h * off : -(h * off));
    if (v < 0) v = 0;
    return v;
  endfunction

  task automatic zero_model();
    for (int i = 0; i < N; i++) begin
      ph0[i] = 0;
      ph1[i] = 0;
    end
  endtask

  // One full frame with handshakes; dly < 0 picks a random hold per sample
  task automatic run_frame(input int f, input int off, input int dly, input bit spur,
                           input int sync_h, output int n_hs);
    int k, fe0, fe1, dcount;
    bit got, ended;
    logic [LAW-1:0] ea0, ea1;
    logic [SW-1:0]  es0, es1;
    logic [HW-1:0]  eh;
    n_hs  = 0;
    ended = 1'b0;
    @(negedge clk);
    freq = PW'(f);
    offs = PW'(off);
    frame_start = 1'b1;
    for (int h = 0; h < int'(N) && !ended; h++) begin
      fe0 = model_f(h, f, off, 0);
      fe1 = model_f(h, f, off, 1);
      k   = 0;
      got = 1'b0;
      while (!got && k < 30) begin
        @(negedge clk);
        k++;
        if (k == 1) begin
          frame_start = 1'b0;
          next_sample = spur;
          phase_sync  = 1'b0;
        end
        if (k == 2) next_sample = 1'b0;
        if (h == 0 && k == 1) begin
          checks++;
          if (too0 !== 1'b0 || too1 !== 1'b0) begin
            errors++;
            $display("FAIL too_high_clear: got %b/%b required 0/0", too0, too1);
          end
        end
        if (rdy0 === 1'b1 || done0 === 1'b1) got = 1'b1;
      end
      if (fe0 > LIMIT) begin
        checks++;
        if (!(k == 2 && done0 === 1'b1 && too0 === 1'b1 && rdy0 === 1'b0)) begin
          errors++;
          $display("FAIL trunc_h%0d: k=%0d done=%b too_high=%b ready=%b required k=2 done=1 too_high=1 ready=0",
                   h, k, done0, too0, rdy0);
        end
        checks++;
        if (done1 !== 1'b1 || too1 !== 1'b1) begin
          errors++;
          $display("FAIL trunc_mode1_h%0d: done=%b too_high=%b required 1 1", h, done1, too1);
        end
        ended = 1'b1;
      end else begin
        ph0[h] = (ph0[h] + fe0) % 65536;
        ph1[h] = (ph1[h] + fe1) % 65536;
        ea0 = LAW'(ph0[h] >> (PW - LAW));
        ea1 = LAW'(ph1[h] >> (PW - LAW));
        es0 = lut_fn(ea0);
        es1 = lut_fn(ea1);
        eh  = HW'(h);
        checks++;
        if (k != 4 || rdy0 !== 1'b1 || rdy1 !== 1'b1 || done0 !== 1'b0) begin
          errors++;
          $display("FAIL ready_latency_h%0d: k=%0d ready=%b/%b done=%b required k=4 ready=1/1 done=0",
                   h, k, rdy0, rdy1, done0);
        end
        checks++;
        if (addr0 !== ea0 || addr1 !== ea1) begin
          errors++;
          $display("FAIL lut_addr_h%0d: got %0d/%0d required %0d/%0d", h, addr0, addr1, ea0, ea1);
        end
        checks++;
        if (sample0 !== es0 || sample1 !== es1) begin
          errors++;
          $display("FAIL sample_h%0d: got %h/%h required %h/%h", h, sample0, sample1, es0, es1);
        end
        checks++;
        if (harm0 !== eh || harm1 !== eh) begin
          errors++;
          $display("FAIL harmonic_h%0d: got %0d/%0d required %0d", h, harm0, harm1, eh);
        end
        n_hs++;
        dcount = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        for (int d = 0; d < dcount; d++) begin
          @(negedge clk);
          checks++;
          if (rdy0 !== 1'b1 || sample0 !== es0 || harm0 !== eh || addr0 !== ea0) begin
            errors++;
            $display("FAIL hold_h%0d_d%0d: ready=%b sample=%h harm=%0d addr=%0d required 1 %h %0d %0d",
                     h, d, rdy0, sample0, harm0, addr0, es0, eh, ea0);
          end
          frame_start = spur && (d == 0) && (dcount > 1);
        end
        next_sample = 1'b1;
        frame_start = 1'b0;
        if (h == sync_h) phase_sync = 1'b1;
        if (h == int'(N) - 1) begin
          @(negedge clk);
          next_sample = 1'b0;
          phase_sync  = 1'b0;
          checks++;
          if (done0 !== 1'b1 || done1 !== 1'b1 || rdy0 !== 1'b0) begin
            errors++;
            $display("FAIL frame_done: done=%b/%b ready=%b required 1/1 0", done0, done1, rdy0);
          end
          ended = 1'b1;
        end
      end
    end
    @(negedge clk);
    next_sample = 1'b0;
    phase_sync  = 1'b0;
    frame_start = 1'b0;
    checks++;
    if (done0 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL done_single_pulse: done=%b/%b required 0/0", done0, done1);
    end
    if (sync_h >= 0) zero_model();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({addr0, sample0, harm0, rdy0, done0, too0, addr1, sample1, harm1, rdy1, done1, too1} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%0d sample=%h harm=%0d rdy=%b done=%b too=%b required all 0",
               addr0, sample0, harm0, rdy0, done0, too0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    zero_model();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    run_frame(100, 0, 0, 1'b0, -1, n);
    run_frame(100, 0, 1, 1'b0, -1, n);
  endtask

  task automatic test_detune();
    int n;
    run_frame(1000, 10, -1, 1'b0, -1, n);
  endtask

  task automatic test_clamp();
    int n;
    run_frame(10, 20, -1, 1'b0, -1, n);
    run_frame(10, 20, -1, 1'b0, -1, n);
  endtask

  task automatic test_freq_limit();
    int n;
    run_frame(6000, 0, -1, 1'b0, -1, n);
    checks++;
    if (n != 3 || too0 !== 1'b1) begin
      errors++;
      $display("FAIL freq_limit_handshakes: got %0d too_high=%b required 3 1", n, too0);
    end
    run_frame(100, 0, -1, 1'b0, -1, n);
  endtask

  task automatic test_handshake();
    int n;
    run_frame(int'($urandom_range(1, 3000)), int'($urandom_range(0, 200)), 0, 1'b1, -1, n);
    run_frame(int'($urandom_range(1, 3000)), int'($urandom_range(0, 200)), 1, 1'b1, -1, n);
    run_frame(int'($urandom_range(1, 3000)), int'($urandom_range(0, 200)), 7, 1'b1, -1, n);
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 6; i++) begin
      run_frame(int'($urandom_range(1, 3000)), int'($urandom_range(0, 200)), -1,
                1'($urandom_range(0, 1)), -1, n);
    end
  endtask

  task automatic test_phase_sync();
    int n;
    bit saw;
    run_frame(777, 33, -1, 1'b0, 1, n);
    run_frame(100, 0, -1, 1'b0, -1, n);
    @(negedge clk);
    phase_sync  = 1'b1;
    frame_start = 1'b1;
    freq = PW'(100);
    offs = '0;
    @(negedge clk);
    phase_sync  = 1'b0;
    frame_start = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rdy0 !== 1'b0 || done0 !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL sync_beats_start: activity=%b required 0", saw);
    end
    zero_model();
    run_frame(100, 0, -1, 1'b0, -1, n);
  endtask

  task automatic test_reset_mid();
    int k, n;
    bit got, saw;
    @(negedge clk);
    freq = PW'(500);
    offs = '0;
    frame_start = 1'b1;
    k = 0;
    got = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      frame_start = 1'b0;
      if (rdy0 === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL reset_mid_ready: ready not seen in %0d cycles required within 4", k);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({addr0, sample0, harm0, rdy0, done0, too0, addr1, sample1, harm1, rdy1, done1, too1} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: addr=%0d sample=%h harm=%0d rdy=%b done=%b required all 0",
               addr0, sample0, harm0, rdy0, done0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done0 !== 1'b0 || done1 !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL reset_mid_no_done: done seen=%b required 0", saw);
    end
    zero_model();
    run_frame(100, 0, -1, 1'b0, -1, n);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_detune();
    test_clamp();
    test_freq_limit();
    test_handshake();
    test_random();
    test_phase_sync();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
